// File: rtl/udp_txbuf_loader.sv
// CPU-side loader for the shared UDP TX buffer: packs a byte stream into
// 32-bit little-endian words, writes a length header into word 0 and hands
// the buffer to the ROS2 engine with a one-cycle release pulse.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | buffer not owned; wait for the arbiter grant
// FILL      | accept payload bytes, write each completed word
// HDR       | write the length header into word 0
// REL       | pulse the release to the arbiter
// WAIT_DROP | wait for the arbiter to take the grant away
// DRAIN     | swallow the tail of an oversized frame through tlast
module udp_txbuf_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_BYTES  = ((1 << ADDR_WIDTH) - 1) * 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  txbuf_grant,
    output logic                  txbuf_rel,
    output logic [ADDR_WIDTH-1:0] txbuf_addr,
    output logic                  txbuf_ce,
    output logic                  txbuf_we,
    output logic [31:0]           txbuf_wdata,
    output logic                  busy,
    output logic                  overflow,
    output logic                  abort
);

    typedef enum logic [2:0] {
        IDLE, FILL, HDR, REL, WAIT_DROP, DRAIN
    } state_t;

    localparam logic [15:0] MAX_CNT = 16'(MAX_BYTES);

    state_t                state, state_d;
    logic [15:0]           byte_cnt, byte_cnt_d;
    logic [31:0]           word_buf, word_buf_d;
    logic [31:0]           packed_word;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [31:0]           wdata_d;
    logic                  rel_d, ce_d, ovf_d, abort_d, busy_d;
    logic                  accept;

    // Ready follows the grant live so no byte is handshaken after ownership is lost.
    assign s_axis_tready = !rst && ((state == FILL && txbuf_grant) || state == DRAIN);
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Merge the incoming byte into its lane; lane 0 starts a fresh zeroed word.
    always_comb begin
        packed_word = (byte_cnt[1:0] == 2'd0) ? 32'h0 : word_buf;
        case (byte_cnt[1:0])
            2'd0:    packed_word[7:0]   = s_axis_tdata;
            2'd1:    packed_word[15:8]  = s_axis_tdata;
            2'd2:    packed_word[23:16] = s_axis_tdata;
            default: packed_word[31:24] = s_axis_tdata;
        endcase
    end

    // Next-state and next-output logic; every RAM output and pulse is registered below.
    always_comb begin
        state_d    = state;
        byte_cnt_d = byte_cnt;
        word_buf_d = word_buf;
        addr_d     = txbuf_addr;
        wdata_d    = txbuf_wdata;
        rel_d      = 1'b0;
        ce_d       = 1'b0;
        ovf_d      = 1'b0;
        abort_d    = 1'b0;
        case (state)
            IDLE: begin
                if (txbuf_grant) state_d = FILL;
            end
            FILL: begin
                if (!txbuf_grant) begin
                    // Partial contents are abandoned; the engine never sees them.
                    state_d    = IDLE;
                    byte_cnt_d = 16'd0;
                    abort_d    = (byte_cnt != 16'd0);
                end else if (accept) begin
                    if (byte_cnt == MAX_CNT) begin
                        ovf_d      = 1'b1;
                        byte_cnt_d = 16'd0;
                        state_d    = s_axis_tlast ? FILL : DRAIN;
                    end else begin
                        word_buf_d = packed_word;
                        byte_cnt_d = byte_cnt + 16'd1;
                        if (byte_cnt[1:0] == 2'd3 || s_axis_tlast) begin
                            ce_d    = 1'b1;
                            addr_d  = ADDR_WIDTH'(byte_cnt[15:2]) + ADDR_WIDTH'(1);
                            wdata_d = packed_word;
                        end
                        if (s_axis_tlast) state_d = HDR;
                    end
                end
            end
            HDR: begin
                ce_d    = 1'b1;
                addr_d  = '0;
                wdata_d = {16'h0000, byte_cnt};
                state_d = REL;
            end
            REL: begin
                rel_d   = 1'b1;
                state_d = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (!txbuf_grant) begin
                    state_d    = IDLE;
                    byte_cnt_d = 16'd0;
                end
            end
            DRAIN: begin
                if (accept && s_axis_tlast) state_d = FILL;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == HDR) || (state_d == REL) || (state_d == WAIT_DROP) ||
                 (state_d == DRAIN) || (state_d == FILL && byte_cnt_d != 16'd0);
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_cnt    <= 16'd0;
            word_buf    <= 32'h0;
            txbuf_rel   <= 1'b0;
            txbuf_ce    <= 1'b0;
            txbuf_we    <= 1'b0;
            txbuf_addr  <= '0;
            txbuf_wdata <= 32'h0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            abort       <= 1'b0;
        end else begin
            state       <= state_d;
            byte_cnt    <= byte_cnt_d;
            word_buf    <= word_buf_d;
            txbuf_rel   <= rel_d;
            txbuf_ce    <= ce_d;
            txbuf_we    <= ce_d;
            txbuf_addr  <= addr_d;
            txbuf_wdata <= wdata_d;
            busy        <= busy_d;
            overflow    <= ovf_d;
            abort       <= abort_d;
        end
    end

endmodule

// File: tb/tb_udp_txbuf_loader.sv
// Directed bench for udp_txbuf_loader with a 4-word buffer (MAX_BYTES = 12).
module tb_udp_txbuf_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    s_axis_tdata = 8'h00;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic          txbuf_grant;
    logic          txbuf_rel;
    logic [AW-1:0] txbuf_addr;
    logic          txbuf_ce;
    logic          txbuf_we;
    logic [31:0]   txbuf_wdata;
    logic          busy;
    logic          overflow;
    logic          abort;

    logic          man_grant = 1'b0;
    logic          arb_grant = 1'b1;
    logic          arb_auto  = 1'b0;
    logic [2:0]    gap = 3'd0;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int rel_cnt = 0;
    int ovf_cnt = 0;
    int abort_cnt = 0;
    int last_acc = 0;
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int            wr_cyc[$];
    int            acc_cyc[$];
    int            rel_cycs[$];

    typedef struct packed {
        logic [7:0]  len;
        logic [95:0] bytes;
        logic [95:0] words;
        logic [15:0] hdr;
    } vec_t;

    vec_t vecs [5];

    assign txbuf_grant = arb_auto ? arb_grant : man_grant;

    udp_txbuf_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .txbuf_grant(txbuf_grant), .txbuf_rel(txbuf_rel),
        .txbuf_addr(txbuf_addr), .txbuf_ce(txbuf_ce), .txbuf_we(txbuf_we),
        .txbuf_wdata(txbuf_wdata), .busy(busy), .overflow(overflow), .abort(abort)
    );

    always #5 clk = ~clk;

    // Arbiter model: take the grant on release, give it back a few cycles later.
    always @(posedge clk) begin
        if (txbuf_rel) begin
            arb_grant <= 1'b0;
            gap       <= 3'd3;
        end else if (!arb_grant) begin
            if (gap == 3'd0) arb_grant <= 1'b1;
            else             gap <= gap - 3'd1;
        end
    end

    // Observe RAM writes, pulses and accepted bytes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (txbuf_ce && txbuf_we) begin
            wr_addr.push_back(txbuf_addr);
            wr_data.push_back(txbuf_wdata);
            wr_cyc.push_back(cyc);
        end
        if (txbuf_rel) begin
            rel_cnt <= rel_cnt + 1;
            rel_cycs.push_back(cyc);
        end
        if (overflow) ovf_cnt <= ovf_cnt + 1;
        if (abort) abort_cnt <= abort_cnt + 1;
        if (s_axis_tvalid && s_axis_tready) begin
            acc_cyc.push_back(cyc);
            if (s_axis_tlast) last_acc <= cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_tready();
        int k = 0;
        while (!s_axis_tready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!s_axis_tready) begin
            checks++;
            failures++;
            $display("FAIL tready_timeout actual=0 required=1");
        end
    endtask

    task automatic send_frame(input int n, input logic [127:0] data, input bit last);
        for (int i = 0; i < n; i++) begin
            s_axis_tdata  = data[8*i +: 8];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = last && (i == n - 1);
            wait_tready();
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_rel(input int target);
        int k = 0;
        while (rel_cnt < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (rel_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL rel_timeout actual=%0d required=%0d", rel_cnt, target);
        end
    endtask

    function automatic int count_addr0(input int from);
        int n = 0;
        for (int j = from; j < wr_addr.size(); j++)
            if (wr_addr[j] == '0) n++;
        return n;
    endfunction

    task automatic check_frame(input int nw, input logic [127:0] w, input logic [15:0] hdr,
                               input int base, input int r0);
        wait_rel(r0 + 1);
        repeat (2) @(negedge clk);
        chk("rel_pulses", rel_cnt - r0, 1);
        chk("n_writes", wr_addr.size() - base, nw + 1);
        if (wr_addr.size() - base == nw + 1 && rel_cycs.size() > 0) begin
            for (int j = 0; j < nw; j++) begin
                chk("data_addr", 32'(wr_addr[base+j]), j + 1);
                chk("data_word", wr_data[base+j], w[32*j +: 32]);
            end
            chk("hdr_addr", 32'(wr_addr[base+nw]), 0);
            chk("hdr_word", wr_data[base+nw], {16'h0000, hdr});
            chk("last_word_cyc", wr_cyc[base+nw-1], last_acc + 1);
            chk("hdr_cyc", wr_cyc[base+nw], last_acc + 2);
            chk("rel_cyc", rel_cycs[rel_cycs.size()-1], last_acc + 3);
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int base, r0, o0, a0, abase, rbase, nw;

        vecs[0] = '{8'd5,  96'h0000000000000055_44332211, 96'h00000000_00000055_44332211, 16'd5};
        vecs[1] = '{8'd1,  96'h0000000000000000_000000A5, 96'h00000000_00000000_000000A5, 16'd1};
        vecs[2] = '{8'd12, 96'h0C0B0A09_08070605_04030201, 96'h0C0B0A09_08070605_04030201, 16'd12};
        vecs[3] = '{8'd4,  96'h00000000_00000000_EFBEADDE, 96'h00000000_00000000_EFBEADDE, 16'd4};
        vecs[4] = '{8'd7,  96'h00000000_00706050_40302010, 96'h00000000_00706050_40302010, 16'd7};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {25'h0, s_axis_tready, txbuf_rel, txbuf_ce, txbuf_we, busy, overflow, abort}, 0);
        chk("reset_addr", 32'(txbuf_addr), 0);
        chk("reset_wdata", txbuf_wdata, 0);
        rst = 1'b0;

        // No grant: byte offered but never taken, no RAM traffic
        s_axis_tdata  = 8'hAA;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nogrant_tready", 32'(s_axis_tready), 0);
        end
        chk("nogrant_writes", wr_addr.size(), 0);
        chk("nogrant_accepts", acc_cyc.size(), 0);
        man_grant = 1'b1;
        @(negedge clk);
        chk("grant_tready", 32'(s_axis_tready), 1);
        chk("grant_not_yet", acc_cyc.size(), 0);
        arb_auto = 1'b1;
        r0 = rel_cnt;
        base = wr_addr.size();
        @(negedge clk);
        chk("first_accept", acc_cyc.size(), 1);
        chk("busy_after_first", 32'(busy), 1);
        send_frame(1, 128'hBB, 1'b1);
        check_frame(1, 128'h0000BBAA, 16'd2, base, r0);

        // Table of normal frames with the arbiter model running
        o0 = ovf_cnt;
        a0 = abort_cnt;
        for (int i = 0; i < 5; i++) begin
            base = wr_addr.size();
            r0   = rel_cnt;
            nw   = (int'(vecs[i].len) + 3) / 4;
            send_frame(int'(vecs[i].len), {32'h0, vecs[i].bytes}, 1'b1);
            check_frame(nw, {32'h0, vecs[i].words}, vecs[i].hdr, base, r0);
        end
        chk("table_no_ovf", ovf_cnt - o0, 0);
        chk("table_no_abort", abort_cnt - a0, 0);

        // Oversized frame that needs draining
        base  = wr_addr.size();
        r0    = rel_cnt;
        o0    = ovf_cnt;
        abase = acc_cyc.size();
        send_frame(15, 128'h000F0E0D0C0B0A090807060504030201, 1'b1);
        repeat (6) @(negedge clk);
        chk("ovf_pulses", ovf_cnt - o0, 1);
        chk("ovf_no_rel", rel_cnt - r0, 0);
        chk("ovf_writes", wr_addr.size() - base, 3);
        chk("ovf_no_hdr", count_addr0(base), 0);
        chk("ovf_all_swallowed", acc_cyc.size() - abase, 15);
        if (wr_addr.size() - base == 3) begin
            chk("ovf_w1", wr_data[base], 32'h04030201);
            chk("ovf_w3", wr_data[base+2], 32'h0C0B0A09);
        end
        chk("ovf_busy_done", 32'(busy), 0);
        chk("ovf_still_owned", 32'(s_axis_tready), 1);

        // Oversized byte carrying tlast goes straight back to FILL
        base = wr_addr.size();
        send_frame(13, 128'h00000000_00000D0C0B0A090807060504030201, 1'b1);
        repeat (4) @(negedge clk);
        chk("ovf13_pulses", ovf_cnt - o0, 2);
        chk("ovf13_no_rel", rel_cnt - r0, 0);
        chk("ovf13_no_hdr", count_addr0(base), 0);
        chk("ovf13_busy", 32'(busy), 0);
        base = wr_addr.size();
        send_frame(4, 128'h71615141, 1'b1);
        check_frame(1, 128'h71615141, 16'd4, base, r0);

        // Grant lost after 6 bytes
        man_grant = 1'b1;
        arb_auto  = 1'b0;
        r0 = rel_cnt;
        a0 = abort_cnt;
        send_frame(6, 128'h666564636261, 1'b0);
        man_grant = 1'b0;
        @(negedge clk);
        chk("abort_pulse", 32'(abort), 1);
        chk("abort_tready", 32'(s_axis_tready), 0);
        chk("abort_busy", 32'(busy), 0);
        @(negedge clk);
        chk("abort_single", 32'(abort), 0);
        chk("abort_count", abort_cnt - a0, 1);
        chk("abort_no_rel", rel_cnt - r0, 0);
        man_grant = 1'b1;
        @(negedge clk);
        arb_auto = 1'b1;
        base = wr_addr.size();
        send_frame(2, 128'hC2C1, 1'b1);
        check_frame(1, 128'h0000C2C1, 16'd2, base, r0);

        // Back-to-back frames: second waits for the grant to come back
        base  = wr_addr.size();
        r0    = rel_cnt;
        abase = acc_cyc.size();
        rbase = rel_cycs.size();
        send_frame(4, 128'h04030201, 1'b1);
        send_frame(4, 128'h08070605, 1'b1);
        wait_rel(r0 + 2);
        repeat (3) @(negedge clk);
        chk("b2b_rel_pulses", rel_cnt - r0, 2);
        chk("b2b_writes", wr_addr.size() - base, 4);
        if (wr_addr.size() - base == 4) begin
            chk("b2b_w1", wr_data[base], 32'h04030201);
            chk("b2b_hdr1_addr", 32'(wr_addr[base+1]), 0);
            chk("b2b_hdr1", wr_data[base+1], 32'h00000004);
            chk("b2b_w2", wr_data[base+2], 32'h08070605);
            chk("b2b_hdr2_addr", 32'(wr_addr[base+3]), 0);
            chk("b2b_hdr2", wr_data[base+3], 32'h00000004);
        end
        if (acc_cyc.size() - abase == 8 && rel_cycs.size() - rbase == 2)
            chk("b2b_wait_grant", acc_cyc[abase+4], rel_cycs[rbase] + 6);
        else
            chk("b2b_accepts", acc_cyc.size() - abase, 8);
        repeat (10) @(negedge clk);

        // Reset while the header is pending
        base = wr_addr.size();
        r0   = rel_cnt;
        send_frame(2, 128'hE2E1, 1'b1);
        chk("hdr_state_write", 32'(txbuf_ce), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_hdr_ctrl", {25'h0, s_axis_tready, txbuf_rel, txbuf_ce, txbuf_we, busy, overflow, abort}, 0);
        chk("rst_hdr_addr", 32'(txbuf_addr), 0);
        chk("rst_hdr_wdata", txbuf_wdata, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_hdr_no_rel", rel_cnt - r0, 0);
        chk("rst_hdr_no_hdr", count_addr0(base), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=done", cyc);
        $fatal(1, "timeout");
    end

endmodule
